// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel definitions shared by the host arbiter and its bench.
// tl_h2d_t : host-to-device A channel plus the host's D-channel ready.
// tl_d2h_t : device-to-host D channel plus the device's A-channel ready.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb2.sv
// Two-host to one-device TL-UL arbiter (host 0 = LSU, host 1 = instruction
// fetch). Round-robin selection with a request lock so a presented request is
// never withdrawn; responses are steered by an in-order FIFO of grant IDs.
// Both A and D channels pass through combinationally (no added latency).
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   tl_h0_i/o        host 0 request / response
//   tl_h1_i/o        host 1 request / response
//   tl_dev_o/i       shared device request / response
//   outstanding_o    accepted requests still awaiting a response
//   spurious_rsp_o   sticky: device d_valid seen with no request in flight
//
// Lock state machine
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   StIdle    | selection follows the round-robin rules every cycle
//   StLocked  | a request was presented but not accepted; lock_id_q is held
//             | until that request's handshake completes
module tlul_host_arb2 #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          H0Prio         = 1'b1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  tlul_pkg::tl_h2d_t                      tl_h0_i,
    output tlul_pkg::tl_d2h_t                      tl_h0_o,
    input  tlul_pkg::tl_h2d_t                      tl_h1_i,
    output tlul_pkg::tl_d2h_t                      tl_h1_o,
    output tlul_pkg::tl_h2d_t                      tl_dev_o,
    input  tlul_pkg::tl_d2h_t                      tl_dev_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
    output logic                                   spurious_rsp_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {
        StIdle,
        StLocked
    } lock_state_e;

    lock_state_e               state_q;
    logic                      lock_id_q;
    logic                      rr_ptr_q;
    logic                      active_q;
    logic [MaxOutstanding-1:0] fifo_id_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [CntW-1:0]           count_q;
    logic                      spurious_q;

    logic sel_id;
    logic sel_valid;
    logic fifo_full;
    logic fifo_empty;
    logic head_id;
    logic dev_a_valid;
    logic dev_d_ready;
    logic host_a_ready;
    logic rsp_valid;
    logic accept;
    logic pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        sel_id = 1'b0;
        if (state_q == StLocked) begin
            sel_id = lock_id_q;
        end else if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
            sel_id = ~rr_ptr_q;
        end else if (tl_h1_i.a_valid) begin
            sel_id = 1'b1;
        end
    end

    // active_q keeps every handshake output low until the first clock after
    // reset release, so the device and hosts see a quiet port during reset.
    assign sel_valid    = active_q & (sel_id ? tl_h1_i.a_valid : tl_h0_i.a_valid);
    assign fifo_full    = (count_q == CntW'(MaxOutstanding));
    assign fifo_empty   = (count_q == '0);
    assign head_id      = fifo_id_q[rd_ptr_q];
    assign dev_a_valid  = sel_valid & ~fifo_full;
    assign host_a_ready = tl_dev_i.a_ready & sel_valid & ~fifo_full;
    assign rsp_valid    = active_q & tl_dev_i.d_valid & ~fifo_empty;
    // With nothing in flight the device beat is drained and discarded.
    assign dev_d_ready  = active_q & (fifo_empty ? 1'b1 :
                                      (head_id ? tl_h1_i.d_ready : tl_h0_i.d_ready));
    assign accept       = dev_a_valid & tl_dev_i.a_ready;
    assign pop          = tl_dev_i.d_valid & dev_d_ready & ~fifo_empty;

    always_comb begin
        tl_dev_o         = sel_id ? tl_h1_i : tl_h0_i;
        tl_dev_o.a_valid = dev_a_valid;
        tl_dev_o.d_ready = dev_d_ready;

        tl_h0_o          = tl_dev_i;
        tl_h0_o.a_ready  = host_a_ready & ~sel_id;
        tl_h0_o.d_valid  = rsp_valid & ~head_id;

        tl_h1_o          = tl_dev_i;
        tl_h1_o.a_ready  = host_a_ready & sel_id;
        tl_h1_o.d_valid  = rsp_valid & head_id;
    end

    // A presented-but-unaccepted request (device stall or full FIFO) pins the
    // selection until it is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            lock_id_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (sel_valid && !accept) begin
                        state_q   <= StLocked;
                        lock_id_q <= sel_id;
                    end
                end
                StLocked: begin
                    if (accept) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // rr_ptr_q is the last-served host. Out of reset the host that should
    // lose the first tie is recorded as last served.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q   <= 1'b0;
            rr_ptr_q   <= H0Prio;
            fifo_id_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (accept) begin
                rr_ptr_q            <= sel_id;
                fifo_id_q[wr_ptr_q] <= sel_id;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (tl_dev_i.d_valid && fifo_empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

    assign outstanding_o  = count_q;
    assign spurious_rsp_o = spurious_q;

endmodule

// File: tb/tb_tlul_host_arb2.sv
// Self-checking bench for tlul_host_arb2 (MaxOutstanding = 2, H0Prio = 1).
// Tests queue the expected grant order (by a_source); a monitor run at each
// falling edge checks grants against that queue, records the granted host in
// a response-routing queue, and checks D-channel steering and the in-flight
// count against it.
module tb_tlul_host_arb2;
    import tlul_pkg::*;

    logic       clk;
    logic       rst_n;
    tl_h2d_t    h0_i, h1_i, dev_o;
    tl_d2h_t    h0_o, h1_o, dev_i;
    logic [1:0] outstanding;
    logic       spurious;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] grant_q[$];
    logic       rsp_q[$];
    logic       mon_en   = 1'b0;
    logic       auto_rsp = 1'b0;

    tlul_host_arb2 #(.MaxOutstanding(2), .H0Prio(1'b1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tl_h0_i        (h0_i),
        .tl_h0_o        (h0_o),
        .tl_h1_i        (h1_i),
        .tl_h1_o        (h1_o),
        .tl_dev_o       (dev_o),
        .tl_dev_i       (dev_i),
        .outstanding_o  (outstanding),
        .spurious_rsp_o (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        logic       h;
        logic       exp_rdy;
        if (!mon_en) return;
        check_val("outstanding", 32'(outstanding), 32'(rsp_q.size()));
        if (dev_i.d_valid) begin
            if (rsp_q.size() == 0) begin
                check_val("stray_d_ready", 32'(dev_o.d_ready), 32'd1);
                check_val("stray_h0_d_valid", 32'(h0_o.d_valid), 32'd0);
                check_val("stray_h1_d_valid", 32'(h1_o.d_valid), 32'd0);
            end else begin
                h       = rsp_q[0];
                exp_rdy = h ? h1_i.d_ready : h0_i.d_ready;
                check_val("rsp_h0_d_valid", 32'(h0_o.d_valid), 32'(!h));
                check_val("rsp_h1_d_valid", 32'(h1_o.d_valid), 32'(h));
                check_val("rsp_dev_d_ready", 32'(dev_o.d_ready), 32'(exp_rdy));
                check_val("rsp_d_source", 32'(h ? h1_o.d_source : h0_o.d_source), 32'(dev_i.d_source));
                if (exp_rdy) void'(rsp_q.pop_front());
            end
        end
        if (dev_o.a_valid && dev_i.a_ready) begin
            if (grant_q.size() == 0) begin
                check_val("unexpected_grant", 32'(dev_o.a_source), 32'hffff_ffff);
            end else begin
                e = grant_q.pop_front();
                check_val("grant_source", 32'(dev_o.a_source), 32'(e));
                rsp_q.push_back(e[4]);
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        monitor();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            dev_i.d_valid  = (rsp_q.size() != 0);
            dev_i.d_opcode = AccessAckData;
            dev_i.d_source = 8'hA5;
            dev_i.d_data   = $urandom;
        end
    endtask

    task automatic h0_req(input logic v, input logic [7:0] src);
        h0_i.a_valid   = v;
        h0_i.a_opcode  = Get;
        h0_i.a_source  = src;
        h0_i.a_address = 32'h1000_0000 + {22'd0, src, 2'b00};
        h0_i.a_mask    = 4'hf;
    endtask

    task automatic h1_req(input logic v, input logic [7:0] src);
        h1_i.a_valid   = v;
        h1_i.a_opcode  = Get;
        h1_i.a_source  = src;
        h1_i.a_address = 32'h2000_0000 + {22'd0, src, 2'b00};
        h1_i.a_mask    = 4'hf;
    endtask

    initial begin
        int h0_n;
        int h1_n;
        h0_i  = '0;
        h1_i  = '0;
        dev_i = '0;
        rst_n = 1'b0;

        // Reset: outputs quiet even with live inputs.
        #2;
        h0_req(1'b1, 8'h00);
        h0_i.d_ready   = 1'b1;
        dev_i.a_ready  = 1'b1;
        dev_i.d_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_dev_a_valid", 32'(dev_o.a_valid), 32'd0);
        check_val("rst_dev_d_ready", 32'(dev_o.d_ready), 32'd0);
        check_val("rst_h0_a_ready", 32'(h0_o.a_ready), 32'd0);
        check_val("rst_h0_d_valid", 32'(h0_o.d_valid), 32'd0);
        check_val("rst_h1_d_valid", 32'(h1_o.d_valid), 32'd0);
        check_val("rst_outstanding", 32'(outstanding), 32'd0);
        check_val("rst_spurious", 32'(spurious), 32'd0);
        h0_req(1'b0, 8'h00);
        dev_i.d_valid = 1'b0;
        h1_i.d_ready  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        mon_en   = 1'b1;
        auto_rsp = 1'b1;

        // Contention: both hosts keep requesting; grants alternate from h0.
        grant_q = '{8'h00, 8'h10, 8'h01, 8'h11};
        h0_n = 0;
        h1_n = 0;
        for (int c = 0; c < 7; c++) begin
            h0_req(h0_n < 2, 8'(h0_n));
            h1_req(h1_n < 2, 8'(8'h10 + h1_n));
            settle();
            if (h0_i.a_valid && h0_o.a_ready) h0_n++;
            if (h1_i.a_valid && h1_o.a_ready) h1_n++;
            step();
        end
        h0_req(1'b0, 8'h00);
        h1_req(1'b0, 8'h00);
        check_val("contention_grants_left", 32'(grant_q.size()), 32'd0);
        check_val("contention_rsps_left", 32'(rsp_q.size()), 32'd0);

        // Single host: Get to 0x1000_0000 forwarded in the same cycle.
        grant_q.push_back(8'h00);
        h0_req(1'b1, 8'h00);
        settle();
        check_val("single_dev_a_valid", 32'(dev_o.a_valid), 32'd1);
        check_val("single_dev_addr", dev_o.a_address, 32'h1000_0000);
        step();
        h0_req(1'b0, 8'h00);
        settle();
        check_val("single_outstanding", 32'(outstanding), 32'd1);
        check_val("single_h0_d_valid", 32'(h0_o.d_valid), 32'd1);
        check_val("single_h1_d_valid", 32'(h1_o.d_valid), 32'd0);
        step();
        settle();
        check_val("single_drained", 32'(outstanding), 32'd0);
        step();

        // Backpressure: h1 locked while the device stalls; h0 waits its turn.
        grant_q.push_back(8'h12);
        grant_q.push_back(8'h06);
        dev_i.a_ready = 1'b0;
        h1_req(1'b1, 8'h12);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) h0_req(1'b1, 8'h06);
            settle();
            check_val("lock_dev_source", 32'(dev_o.a_source), 32'h12);
            check_val("lock_dev_addr", dev_o.a_address, 32'h2000_0048);
            check_val("lock_h0_a_ready", 32'(h0_o.a_ready), 32'd0);
            step();
        end
        dev_i.a_ready = 1'b1;
        settle();
        check_val("lock_h1_a_ready", 32'(h1_o.a_ready), 32'd1);
        step();
        h1_req(1'b0, 8'h00);
        settle();
        check_val("lock_h0_next", 32'(h0_o.a_ready), 32'd1);
        step();
        h0_req(1'b0, 8'h00);
        repeat (4) begin settle(); step(); end
        check_val("lock_grants_left", 32'(grant_q.size()), 32'd0);

        // FIFO full: device withholds responses.
        auto_rsp      = 1'b0;
        dev_i.d_valid = 1'b0;
        grant_q       = '{8'h07, 8'h08, 8'h09};
        h0_n          = 7;
        for (int c = 0; c < 4; c++) begin
            h0_req(1'b1, 8'(h0_n));
            settle();
            if (c >= 2) begin
                check_val("full_dev_a_valid", 32'(dev_o.a_valid), 32'd0);
                check_val("full_outstanding", 32'(outstanding), 32'd2);
            end
            if (h0_o.a_ready) h0_n++;
            step();
        end
        dev_i.d_valid  = 1'b1;
        dev_i.d_source = 8'h07;
        settle();
        check_val("full_pop_cycle_a_valid", 32'(dev_o.a_valid), 32'd0);
        step();
        dev_i.d_valid = 1'b0;
        settle();
        check_val("full_after_pop_a_valid", 32'(dev_o.a_valid), 32'd1);
        step();
        h0_req(1'b0, 8'h00);
        auto_rsp = 1'b1;
        repeat (4) begin settle(); step(); end
        check_val("full_grants_left", 32'(grant_q.size()), 32'd0);

        // Host D stall: head is h0 with d_ready low.
        auto_rsp      = 1'b0;
        dev_i.d_valid = 1'b0;
        grant_q.push_back(8'h0a);
        h0_req(1'b1, 8'h0a);
        settle();
        step();
        h0_req(1'b0, 8'h00);
        h0_i.d_ready   = 1'b0;
        dev_i.d_valid  = 1'b1;
        dev_i.d_source = 8'h0a;
        for (int c = 0; c < 2; c++) begin
            settle();
            check_val("stall_dev_d_ready", 32'(dev_o.d_ready), 32'd0);
            check_val("stall_h1_d_valid", 32'(h1_o.d_valid), 32'd0);
            step();
        end
        h0_i.d_ready = 1'b1;
        settle();
        step();
        dev_i.d_valid = 1'b0;
        settle();
        check_val("stall_drained", 32'(outstanding), 32'd0);
        step();

        // Spurious response with an empty FIFO.
        check_val("pre_spurious", 32'(spurious), 32'd0);
        dev_i.d_valid  = 1'b1;
        dev_i.d_source = 8'h33;
        settle();
        step();
        dev_i.d_valid = 1'b0;
        settle();
        check_val("spurious_set", 32'(spurious), 32'd1);
        step();
        step();
        settle();
        check_val("spurious_sticky", 32'(spurious), 32'd1);
        step();

        // Asynchronous reset with two requests in flight.
        grant_q = '{8'h0b, 8'h0c};
        h0_req(1'b1, 8'h0b);
        settle();
        step();
        h0_req(1'b1, 8'h0c);
        settle();
        step();
        settle();
        check_val("prereset_outstanding", 32'(outstanding), 32'd2);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_outstanding", 32'(outstanding), 32'd0);
        check_val("async_spurious", 32'(spurious), 32'd0);
        check_val("async_dev_a_valid", 32'(dev_o.a_valid), 32'd0);
        grant_q.delete();
        rsp_q.delete();
        h0_req(1'b0, 8'h00);
        dev_i.d_valid  = 1'b1;
        dev_i.d_source = 8'h0b;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("released_spurious_low", 32'(spurious), 32'd0);
        step();
        dev_i.d_valid = 1'b0;
        @(negedge clk);
        check_val("late_rsp_spurious", 32'(spurious), 32'd1);
        check_val("late_rsp_outstanding", 32'(outstanding), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
